// File: rtl/xlr8_dm_dma.sv
`default_nettype none
// ============================================================================
// Module   : xlr8_dm_dma
// Purpose  : Byte-wide copy/fill DMA initiator on the single-port DM RAM bus.
// Revision : 1.0  initial release
// ============================================================================
module xlr8_dm_dma #(
    parameter int ADDR_W = 16
) (
    input  logic              cp2,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [7:0]        fill_val,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_ce,
    output logic [15:0]       mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout
);

    localparam logic [1:0]        c_IDLE = 2'd0;
    localparam logic [1:0]        c_RD   = 2'd1;
    localparam logic [1:0]        c_WR   = 2'd2;
    localparam logic [ADDR_W-1:0] c_ZERO = '0;
    localparam logic [ADDR_W-1:0] c_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_last;
    logic              r_mode;
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [ADDR_W-1:0] r_rem;
    logic [7:0]        r_fill;
    logic [7:0]        r_data;
    logic              r_fresh;
    logic              r_done;
    logic [ADDR_W-1:0] w_addr;

    // Abort has priority over a grant for the state decision; the granted
    // access itself still happens at the RAM and is accounted for below.
    always_comb begin
        w_state_nxt = r_state;
        w_last      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start && (len != c_ZERO))
                    w_state_nxt = mode ? c_WR : c_RD;
            end
            c_RD: begin
                if (abort)
                    w_state_nxt = c_IDLE;
                else if (mem_gnt)
                    w_state_nxt = c_WR;
            end
            c_WR: begin
                if (abort) begin
                    w_state_nxt = c_IDLE;
                end else if (mem_gnt) begin
                    if (r_rem == c_ONE) begin
                        w_state_nxt = c_IDLE;
                        w_last      = 1'b1;
                    end else begin
                        w_state_nxt = r_mode ? c_WR : c_RD;
                    end
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge cp2) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_mode    <= 1'b0;
            r_src_ptr <= c_ZERO;
            r_dst_ptr <= c_ZERO;
            r_rem     <= c_ZERO;
            r_fill    <= 8'h00;
            r_data    <= 8'h00;
            r_fresh   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_mode    <= mode;
                        r_src_ptr <= src_addr;
                        r_dst_ptr <= dst_addr;
                        r_rem     <= len;
                        r_fill    <= fill_val;
                        r_fresh   <= 1'b0;
                        if (len == c_ZERO)
                            r_done <= 1'b1;
                    end
                end
                c_RD: begin
                    if (mem_gnt) begin
                        r_src_ptr <= r_src_ptr + c_ONE;
                        r_fresh   <= 1'b1;
                    end
                end
                c_WR: begin
                    // Capture the read byte on its only valid cycle so it
                    // survives a stalled write.
                    if (r_fresh) begin
                        r_data  <= mem_dout;
                        r_fresh <= 1'b0;
                    end
                    if (mem_gnt) begin
                        r_dst_ptr <= r_dst_ptr + c_ONE;
                        r_rem     <= r_rem - c_ONE;
                        if (w_last)
                            r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != c_IDLE);
    assign done    = r_done;
    assign mem_req = (r_state == c_RD) || (r_state == c_WR);
    assign mem_ce  = mem_req;
    assign mem_we  = (r_state == c_WR);
    assign w_addr  = (r_state == c_RD) ? r_src_ptr :
                     (r_state == c_WR) ? r_dst_ptr : c_ZERO;

    always_comb begin
        mem_din = 8'h00;
        if (r_state == c_WR)
            mem_din = r_mode ? r_fill : (r_fresh ? mem_dout : r_data);
    end

    generate
        if (ADDR_W < 16) begin : g_addr_pad
            assign mem_addr = {{(16-ADDR_W){1'b0}}, w_addr};
        end else begin : g_addr_full
            assign mem_addr = w_addr[15:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_xlr8_dm_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_xlr8_dm_dma
// Purpose  : Scoreboard bench for xlr8_dm_dma with a behavioural DM RAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_xlr8_dm_dma;

    logic        cp2 = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic [7:0]  fill_val = '0;
    logic        abort = 1'b0;
    logic        busy, done, mem_req, mem_ce, mem_we;
    logic        mem_gnt = 1'b1;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout = 8'hEE;

    logic [7:0]  ram [0:65535];
    logic [23:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 cp2 = ~cp2;

    xlr8_dm_dma #(.ADDR_W(16)) dut (
        .cp2(cp2), .rst(rst), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .fill_val(fill_val), .abort(abort), .busy(busy), .done(done),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_ce(mem_ce),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    // Read data is only meaningful for one cycle; otherwise it shows junk.
    always @(posedge cp2) begin
        if (mem_ce && mem_gnt && mem_we)
            ram[mem_addr] <= mem_din;
        if (mem_ce && mem_gnt && !mem_we)
            mem_dout <= ram[mem_addr];
        else
            mem_dout <= 8'hEE;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    always @(negedge cp2) begin
        if (mem_req && mem_gnt && mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write got %h required none", {mem_addr, mem_din});
            end else begin
                chk("write", {8'h00, mem_addr, mem_din}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    task automatic run(input string nm, input logic md, input logic [15:0] s,
                       input logic [15:0] d, input logic [15:0] l, input logic [7:0] fv,
                       input int n, input int st_lo, input int st_hi,
                       input logic [15:0] hold, input int ab_at, input int rs_at,
                       input int e_busy, input int e_req, input int e_done, input int e_done_at);
        int bc = 0;
        int rc = 0;
        int dc = 0;
        int da = 0;
        @(posedge cp2); #1;
        start = 1'b1; mode = md; src_addr = s; dst_addr = d; len = l; fill_val = fv;
        mem_gnt = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(posedge cp2); #1;
            start   = 1'b0;
            mem_gnt = !(i >= st_lo && i <= st_hi);
            abort   = (i == ab_at);
            rst     = (i == rs_at);
            @(negedge cp2);
            if (busy) bc++;
            if (mem_req) rc++;
            if (done) begin
                dc++;
                if (da == 0) da = i;
            end
            if (i >= st_lo && i <= st_hi) begin
                chk({nm, "_stall_req"}, {31'd0, mem_req}, 32'd1);
                chk({nm, "_stall_addr"}, {16'd0, mem_addr}, {16'd0, hold});
            end
            if (rs_at != 0 && i == rs_at + 1)
                chk({nm, "_rst_outputs"},
                    {5'd0, busy, done, mem_req, mem_ce, mem_we, mem_addr, mem_din}, 32'd0);
        end
        abort = 1'b0; rst = 1'b0; mem_gnt = 1'b1;
        chk({nm, "_busy_cycles"}, bc, e_busy);
        chk({nm, "_req_cycles"}, rc, e_req);
        chk({nm, "_done_count"}, dc, e_done);
        chk({nm, "_done_cycle"}, da, e_done_at);
        chk({nm, "_missing_writes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
        ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22;
        ram[16'h0102] = 8'h33; ram[16'h0103] = 8'h44;

        repeat (3) @(posedge cp2);
        @(negedge cp2);
        chk("reset_outputs", {5'd0, busy, done, mem_req, mem_ce, mem_we, mem_addr, mem_din}, 32'd0);
        @(posedge cp2); #1;
        rst = 1'b0;

        push(16'h0200, 8'h11); push(16'h0201, 8'h22); push(16'h0202, 8'h33); push(16'h0203, 8'h44);
        run("copy", 1'b0, 16'h0100, 16'h0200, 16'd4, 8'h00, 12, 0, -1, 16'h0, 0, 0, 8, 8, 1, 9);

        push(16'h0FFE, 8'hA5); push(16'h0FFF, 8'hA5); push(16'h1000, 8'hA5); push(16'h1001, 8'hA5);
        run("fill", 1'b1, 16'h0000, 16'h0FFE, 16'd4, 8'hA5, 8, 0, -1, 16'h0, 0, 0, 4, 4, 1, 5);

        push(16'h0210, 8'h11); push(16'h0211, 8'h22);
        run("stall", 1'b0, 16'h0100, 16'h0210, 16'd2, 8'h00, 14, 2, 6, 16'h0210, 0, 0, 9, 9, 1, 10);

        push(16'hFFFF, 8'h3C); push(16'h0000, 8'h3C);
        run("wrap", 1'b1, 16'h0000, 16'hFFFF, 16'd2, 8'h3C, 6, 0, -1, 16'h0, 0, 0, 2, 2, 1, 3);

        run("len0", 1'b0, 16'h0100, 16'h0700, 16'd0, 8'h00, 4, 0, -1, 16'h0, 0, 0, 0, 0, 1, 1);

        push(16'h0300, 8'h77); push(16'h0301, 8'h77); push(16'h0302, 8'h77);
        run("abort", 1'b1, 16'h0000, 16'h0300, 16'd8, 8'h77, 8, 0, -1, 16'h0, 3, 0, 3, 3, 0, 0);

        push(16'h0400, 8'h11);
        run("rst", 1'b0, 16'h0100, 16'h0400, 16'd4, 8'h00, 6, 0, -1, 16'h0, 0, 3, 3, 3, 0, 0);

        push(16'h0600, 8'h11); push(16'h0601, 8'h22); push(16'h0602, 8'h33); push(16'h0603, 8'h44);
        run("copy2", 1'b0, 16'h0200, 16'h0600, 16'd4, 8'h00, 12, 0, -1, 16'h0, 0, 0, 8, 8, 1, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
